// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   WORD_BYTES : bytes per instruction word (PC stride)
//   PC_W       : program counter width
//   NOP_INST   : value presented on inst while the queue is empty
//   fetch_entry_t : one instruction-queue entry {inst, pc}
//   word_align : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int WORD_BYTES = 4;
  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the instruction queue and the PC tag FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empties the FIFO at the next edge (dominates push/pop)
//   push, push_data : write one entry (caller guarantees space)
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (undefined when count == 0)
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to a
// pipelined, in-order instruction memory and queues returned words (with
// their PC) for the decoder. A redirect flushes the queue and drops every
// response still in flight for the old stream.
//   clk, reset        : clock, asynchronous active-high reset
//   imem_req/addr/gnt : request channel, accepted when imem_req && imem_gnt
//   imem_rvalid/rdata : in-order response channel
//   inst_valid/inst/inst_pc/inst_ready : decoder channel, pop on valid && ready
//   redirect, redirect_pc : one-cycle pulse restarting fetch at redirect_pc
//   misalign_err      : sticky, a redirect target had nonzero low bits
//   proto_err         : sticky, a response arrived with nothing outstanding
//
// Handshakes: a transfer happens on a rising edge where the sender's valid
// (imem_req, inst_valid) and the receiver's ready (imem_gnt, inst_ready) are
// both high; a stalled request holds its address stable until accepted.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err,
  output logic        proto_err
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CNT_W1 = CNT_W + 1;

  logic              redirect_q;
  logic [PC_W-1:0]   fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  tag_count;
  logic [CNT_W:0]    in_use;
  fetch_entry_t      q_head;
  fetch_entry_t      q_push_data;
  logic [PC_W-1:0]   tag_head;
  logic              q_valid;
  logic              pop;
  logic              accept;
  logic              rsp;
  logic              rsp_drop;
  logic              rsp_keep;

  assign q_valid  = (q_count != '0);
  assign pop      = q_valid && inst_ready;
  assign accept   = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp      = imem_rvalid && (outstanding != '0);
  assign rsp_drop = rsp && (drop_cnt != '0);
  // A response landing on the redirect cycle belongs to the old stream.
  assign rsp_keep = rsp && (drop_cnt == '0) && !redirect;

  assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(rsp);

  // Credit rule: queued entries (after this cycle's pop) plus in-flight
  // requests never exceed DEPTH, so every response has a queue slot.
  // reset gates the request so it is low for as long as reset is held.
  assign in_use   = {1'b0, q_count} - {{CNT_W{1'b0}}, pop} + {1'b0, outstanding};
  assign imem_req = !reset && !redirect_q && (in_use < CNT_W1'(DEPTH));
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_q   <= 1'b0;
      fetch_pc     <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      misalign_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      redirect_q  <= redirect;
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        // Everything still in flight after this edge is stale, including a
        // request accepted this cycle; a response this cycle is already gone.
        drop_cnt <= outstanding_nxt;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + PC_W'(WORD_BYTES);
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
      if (redirect && (redirect_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
      if (imem_rvalid && (outstanding == '0))      proto_err    <= 1'b1;
    end
  end

  assign q_push_data = '{inst: imem_rdata, pc: tag_head};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (reset),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  // Holds the PC of each live (non-stale) accepted request until its data returns.
  fetch_fifo #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (reset),
    .flush     (redirect),
    .push      (accept && !redirect),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (tag_head),
    .count     (tag_count)
  );

  assign inst_valid = q_valid;
  assign inst       = q_valid ? q_head.inst : NOP_INST;
  assign inst_pc    = q_valid ? q_head.pc   : '0;

  // Every in-flight request is either tagged (live) or counted for dropping.
  a_inflight_accounting: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, tag_count} + {1'b0, drop_cnt}) == {1'b0, outstanding}));

endmodule
